// File: rtl/uart_rx_phy_if.sv
// Byte-side interface of the UART receiver PHY.
// master drives rx_data/rx_valid/frame_error/busy; slave observes them.
interface uart_rx_phy_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_error,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_error,
        input busy
    );
endinterface

// File: rtl/uart_rx_phy.sv
// 8N1 UART receiver: 2-flop synchroniser, baud-tick oversampling, byte strobe.
// Ports: clk, rst (sync, active-high), rx_serial (async line),
//   rx_if.master (rx_data, rx_valid, frame_error, busy).
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx_phy #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_serial,
    uart_rx_phy_if.master rx_if
);

    localparam int TICK_DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TC_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
    // Tick that takes sample_cnt to OVERSAMPLE/2-1 is seen at OVERSAMPLE/2-2.
    localparam logic [SW-1:0] SC_MID  = SW'(OVERSAMPLE / 2 - 2);

    if (TICK_DIV < 1) begin : g_bad_div
        $error("uart_rx_phy: TICK_DIV < 1");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_phy: OVERSAMPLE must be even and >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rx_s;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_error_q, frame_error_d;
    logic          busy_q, busy_d;
    logic          tick;
    logic          bit_val;

    assign tick = (tick_cnt_q == TC_LAST);

`ifdef UART_RX_MAJORITY_EN
    // rx_s on the two ticks preceding the current one.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[0], rx_s};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) |
                     (hist_q[1] & rx_s) |
                     (hist_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d      = S_START;
                    tick_cnt_d   = '0;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sample_cnt_q == SC_MID) begin
                        if (!bit_val) begin
                            sample_cnt_d = '0;
                            state_d      = S_DATA;
                        end else begin
                            sample_cnt_d = '0;
                            state_d      = S_IDLE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (sample_cnt_q == SC_LAST) begin
                        shift_d      = {bit_val, shift_q[7:1]};
                        sample_cnt_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (sample_cnt_q == SC_LAST) begin
                        sample_cnt_d = '0;
                        if (bit_val) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = S_WAIT_IDLE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            rx_s          <= 1'b1;
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            sample_cnt_q  <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist_q        <= 2'b11;
`endif
        end else begin
            sync1_q       <= rx_serial;
            rx_s          <= sync1_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
`ifdef UART_RX_MAJORITY_EN
            hist_q        <= hist_d;
`endif
        end
    end

    assign rx_if.rx_data     = rx_data_q;
    assign rx_if.rx_valid    = rx_valid_q;
    assign rx_if.frame_error = frame_error_q;
    assign rx_if.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_phy.sv
// Self-checking bench for uart_rx_phy at 16 clk per bit.
// Table-driven single frames plus hand-written multi-cycle sequences.
module tb_uart_rx_phy;

    logic clk;
    logic rst;
    logic line;

    uart_rx_phy_if rx_if ();

    uart_rx_phy #(
        .CLK_FREQ_HZ(16_000_000),
        .BAUD_RATE  (1_000_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_serial(line),
        .rx_if    (rx_if)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvalid = 0;
    int nfe = 0;
    logic prev_strobe = 1'b0;
    logic prev_busy = 1'b0;
    int valid_cyc[$];
    logic [7:0] valid_byte[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor: exclusivity, no back-to-back strobes, busy drop.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.rx_valid || rx_if.frame_error) begin
                checks++;
                if ((rx_if.rx_valid && rx_if.frame_error) || prev_strobe) begin
                    errors++;
                    $display("FAIL strobe_rule: v=%0b fe=%0b prev=%0b",
                             rx_if.rx_valid, rx_if.frame_error, prev_strobe);
                end
            end
            if (rx_if.rx_valid) begin
                nvalid++;
                valid_cyc.push_back(cyc);
                valid_byte.push_back(rx_if.rx_data);
                checks++;
                if (rx_if.busy !== 1'b0 || prev_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_strobe: busy=%0b prev=%0b req 0/1",
                             rx_if.busy, prev_busy);
                end
            end
            if (rx_if.frame_error) nfe++;
        end
        prev_strobe = rx_if.rx_valid | rx_if.frame_error;
        prev_busy   = rx_if.busy;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // j: 0 start, 1..8 data LSB first, 9 stop.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int glitch_j, input int rst_j);
        logic b;
        for (int j = 0; j < 10; j++) begin
            if (j == 0) b = 1'b0;
            else if (j == 9) b = stop;
            else b = d[j-1];
            line = b;
            if (j == glitch_j) begin
                step(7);
                line = ~b;
                step(1);
                line = b;
                step(8);
            end else if (j == rst_j) begin
                step(8);
                rst = 1'b1;
                step(1);
                rst = 1'b0;
                step(7);
            end else begin
                step(16);
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int nv0;
        int nf0;
        int i0;

        vecs[0] = '{8'h7B, 1'b1, 1, 0, 8'h7B};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h55, 1'b1, 1, 0, 8'h55};
        vecs[4] = '{8'hA5, 1'b0, 0, 1, 8'h55};

        rst  = 1'b1;
        line = 1'b1;
        step(3);
        chk("reset_rx_data", {24'h0, rx_if.rx_data}, 32'h0);
        chk("reset_rx_valid", {31'h0, rx_if.rx_valid}, 32'h0);
        chk("reset_frame_error", {31'h0, rx_if.frame_error}, 32'h0);
        chk("reset_busy", {31'h0, rx_if.busy}, 32'h0);
        rst = 1'b0;
        step(20);

        for (int i = 0; i < 5; i++) begin
            nv0 = nvalid;
            nf0 = nfe;
            send_frame(vecs[i].data, vecs[i].stop, -1, -1);
            line = 1'b1;
            step(32);
            chk($sformatf("vec%0d_valid_cnt", i), nvalid - nv0, vecs[i].exp_valid);
            chk($sformatf("vec%0d_fe_cnt", i), nfe - nf0, vecs[i].exp_fe);
            chk($sformatf("vec%0d_rx_data", i), {24'h0, rx_if.rx_data},
                {24'h0, vecs[i].exp_data});
        end

        // Back-to-back frames, no idle gap.
        nv0 = nvalid;
        i0 = valid_cyc.size();
        send_frame(8'h57, 1'b1, -1, -1);
        send_frame(8'h7D, 1'b1, -1, -1);
        line = 1'b1;
        step(32);
        chk("b2b_valid_cnt", nvalid - nv0, 2);
        if (valid_cyc.size() >= i0 + 2) begin
            chk("b2b_spacing", valid_cyc[i0+1] - valid_cyc[i0], 160);
            chk("b2b_byte0", {24'h0, valid_byte[i0]}, 32'h57);
            chk("b2b_byte1", {24'h0, valid_byte[i0+1]}, 32'h7D);
        end

        // False start: 4 clk low pulse.
        nv0 = nvalid;
        nf0 = nfe;
        line = 1'b0;
        step(4);
        line = 1'b1;
        step(10);
        chk("glitch_busy_idle", {31'h0, rx_if.busy}, 32'h0);
        step(30);
        chk("glitch_no_valid", nvalid - nv0, 0);
        chk("glitch_no_fe", nfe - nf0, 0);

        // Bad stop, break held low, then a good frame.
        nv0 = nvalid;
        nf0 = nfe;
        send_frame(8'hA5, 1'b0, -1, -1);
        line = 1'b0;
        step(40);
        chk("break_fe_cnt", nfe - nf0, 1);
        chk("break_rx_data_kept", {24'h0, rx_if.rx_data}, 32'h7D);
        chk("break_busy", {31'h0, rx_if.busy}, 32'h1);
        line = 1'b1;
        step(32);
        send_frame(8'h2C, 1'b1, -1, -1);
        line = 1'b1;
        step(32);
        chk("break_fe_total", nfe - nf0, 1);
        chk("after_break_valid", nvalid - nv0, 1);
        chk("after_break_data", {24'h0, rx_if.rx_data}, 32'h2C);

        // Reset during bit 4 of 8'hFF, then 8'h31.
        nv0 = nvalid;
        nf0 = nfe;
        send_frame(8'hFF, 1'b1, -1, 5);
        line = 1'b1;
        step(32);
        chk("abort_no_valid", nvalid - nv0, 0);
        chk("abort_no_fe", nfe - nf0, 0);
        chk("abort_rx_data_reset", {24'h0, rx_if.rx_data}, 32'h0);
        send_frame(8'h31, 1'b1, -1, -1);
        line = 1'b1;
        step(32);
        chk("post_abort_valid", nvalid - nv0, 1);
        chk("post_abort_data", {24'h0, rx_if.rx_data}, 32'h31);

        // 1-clk high glitch at the sample point of data bit 2 of 8'h00.
        nv0 = nvalid;
        send_frame(8'h00, 1'b1, 3, -1);
        line = 1'b1;
        step(32);
        chk("midbit_glitch_valid", nvalid - nv0, 1);
        chk("midbit_glitch_data", {24'h0, rx_if.rx_data}, {24'h0, GLITCH_EXP});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
